// File: rtl/uvme_cvmcu_probe_arb_if.sv
// Probe event bundle: per-source offers in, one arbitrated entry out.
// Macro UVME_CVMCU_PROBE_TSTAMP_EN adds the out_ts timestamp signal.
interface uvme_cvmcu_probe_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
  , parameter int unsigned TS_W  = 16
`endif
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [ID_W-1:0]           out_id;
  logic [DATA_W-1:0]         out_data;
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
  logic [TS_W-1:0]           out_ts;
`endif

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_id, out_data
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
    , input out_ts
`endif
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_id, out_data
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
    , output out_ts
`endif
  );
endinterface

// File: rtl/uvme_cvmcu_probe_arb.sv
// Round-robin arbiter merging NUM_REQ probe event sources into one registered output entry.
// Macro UVME_CVMCU_PROBE_TSTAMP_EN adds a free-running grant timestamp on out_ts.
module uvme_cvmcu_probe_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
  , parameter int unsigned TS_W  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    flush,
  uvme_cvmcu_probe_arb_if.slave   bus,
  output logic [15:0]             grant_cnt
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  logic [DATA_W-1:0] win_data;
  logic              found;
  logic              slot_free;
  logic              grant;
  logic              out_valid_q;
  logic [ID_W-1:0]   out_id_q;
  logic [DATA_W-1:0] out_data_q;

  assign slot_free = !out_valid_q || bus.out_ready;
  // reset_n gating keeps req_ready low for the whole reset window
  assign grant = reset_n && enable && slot_free && !flush && (|bus.req_valid);

  always_comb begin
    winner   = '0;
    win_data = '0;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found    = 1'b1;
        winner   = cand;
        win_data = bus.req_data[cand*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_data  = out_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_data_q  <= '0;
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      grant_cnt   <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_id_q    <= winner;
      out_data_q  <= win_data;
      rr_ptr      <= winner;
      if (grant_cnt != '1) grant_cnt <= grant_cnt + 16'd1;
    end else if (flush || bus.out_ready) begin
      // flush discards even when out_ready is also high; payload fields keep last value
      out_valid_q <= 1'b0;
    end
  end

`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] out_ts_q;

  assign bus.out_ts = out_ts_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt   <= '0;
      out_ts_q <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (grant) out_ts_q <= ts_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_uvme_cvmcu_probe_arb.sv
// Randomized and directed checks of uvme_cvmcu_probe_arb against a cycle-level reference model.
// Define UVME_CVMCU_PROBE_TSTAMP_EN to also check out_ts with a 4-bit timestamp.
module tb_uvme_cvmcu_probe_arb;
  localparam int N  = 4;
  localparam int DW = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit       m_valid;
  int       m_id, m_ptr, m_tsc, m_ts;
  bit [7:0] m_data;
  int       m_cnt;

`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
  uvme_cvmcu_probe_arb_if #(.NUM_REQ(N), .DATA_W(DW), .TS_W(4)) bus ();
  uvme_cvmcu_probe_arb #(.NUM_REQ(N), .DATA_W(DW), .TS_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .bus(bus), .grant_cnt(grant_cnt));
`else
  uvme_cvmcu_probe_arb_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  uvme_cvmcu_probe_arb #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush), .bus(bus), .grant_cnt(grant_cnt));
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_data = 0; m_ptr = N - 1; m_cnt = 0; m_tsc = 0; m_ts = 0;
  endtask

  task automatic check_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check("out_id", 32'(bus.out_id), 32'(m_id));
    check("out_data", 32'(bus.out_data), 32'(m_data));
    check("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
    check("out_ts", 32'(bus.out_ts), 32'(m_ts));
`endif
  endtask

  // Called 1 time unit after a posedge with inputs already set; returns 1 after the next posedge.
  task automatic cycle();
    bit   g;
    int   w;
    logic [N-1:0] exp_rdy;
    #2;
    g = enable && (!m_valid || bus.out_ready) && !flush && (bus.req_valid != 0);
    w = g ? pick(bus.req_valid, m_ptr) : -1;
    exp_rdy = g ? N'(1 << w) : '0;
    check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (g) begin
      m_valid = 1; m_id = w; m_data = bus.req_data[w*DW +: DW]; m_ptr = w;
      if (m_cnt != 16'hFFFF) m_cnt++;
      m_ts = m_tsc;
    end else if (flush || bus.out_ready) begin
      m_valid = 0;
    end
    m_tsc = (m_tsc + 1) % 16;
    #1;
    check_outputs();
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rdy,
                       input logic en, input logic fl);
    bus.req_valid = v; bus.req_data = d; bus.out_ready = rdy; enable = en; flush = fl;
  endtask

  initial begin
    int c0;
    drive('0, '0, 1'b0, 1'b1, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check("reset_ready", 32'(bus.req_ready), 32'd0);
    check_outputs();
    reset_n = 1'b1;

    // round robin 0,1,2,3,0 with all sources valid
    drive('1, 32'h44332211, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("rr_seq", 32'(bus.out_id), 32'(i % N));
    end
    check("rr_cnt", 32'(grant_cnt), 32'd5);

    // backpressure: hold id=2 data=A5 while others request
    drive(4'b0100, 32'h00A50000, 1'b1, 1'b1, 1'b0);
    cycle();
    check("bp_id", 32'(bus.out_id), 32'd2);
    drive(4'b1011, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_hold_data", 32'(bus.out_data), 32'hA5);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_next_id", 32'(bus.out_id), 32'd3);

    // flush with out_ready: discard, no grant, count unchanged
    c0 = m_cnt;
    drive('1, 32'h01020304, 1'b1, 1'b1, 1'b1);
    cycle();
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_cnt", 32'(grant_cnt), 32'(c0));

    // enable gating
    drive(4'b0100, 32'h00770000, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    enable = 1'b1;
    cycle();
    check("en_id", 32'(bus.out_id), 32'd2);

    // asynchronous reset while an entry is held
    drive('1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    cycle();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_async_ready", 32'(bus.req_ready), 32'd0);
    check_outputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    check("rst_first_id", 32'(bus.out_id), 32'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(N'($urandom), ($urandom), 1'($urandom % 2), ($urandom % 8) != 0, ($urandom % 10) == 0);
      cycle();
    end

`ifdef UVME_CVMCU_PROBE_TSTAMP_EN
    // timestamp wrap: grants at counter 15 then 0
    drive('0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_tsc != 15; i++) cycle();
    drive('1, 32'h11223344, 1'b1, 1'b1, 1'b0);
    cycle();
    check("ts_15", 32'(bus.out_ts), 32'd15);
    cycle();
    check("ts_wrap", 32'(bus.out_ts), 32'd0);
`endif

    // grant counter saturation
    drive('1, 32'hA1B2C3D4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 70000 && m_cnt < 16'hFFFE; i++) cycle();
    check("sat_pre", 32'(grant_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) cycle();
    check("sat_cnt", 32'(grant_cnt), 32'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
